// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  // Loader session states; CSUM is only reachable when checksumming is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } loader_state_t;

  // Header is one little-endian length word; payload words are 4 bytes each.
  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//
// Byte stream handshake: a byte moves from source to loader only on a rising
// clock edge where byte_valid && byte_ready. The source must hold byte_data
// stable while byte_valid is high and the byte has not yet transferred;
// byte_ready never depends combinationally on byte_valid.
interface instr_loader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Byte source and memory sink side.
  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/instr_loader_byte_assembler.sv
// Little-endian byte-to-word assembler shared by the header and payload
// phases. 'word' is the complete word including the byte being taken this
// cycle, so it is valid in the same cycle 'last' is high.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        last
);

  logic [1:0]  cnt_q;
  logic [23:0] part_q;

  // Shift accepted bytes in from the top so the first byte ends up lowest.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q  <= 2'd0;
      part_q <= 24'd0;
    end else if (take) begin
      cnt_q  <= cnt_q + 2'd1;
      part_q <= {byte_in, part_q[23:8]};
    end
  end

  // Word completes when the fourth byte of the group is taken.
  always_comb begin
    word = {byte_in, part_q};
    last = take && (cnt_q == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian byte
// image, writes it word by word into instruction memory and holds the core
// in reset until the image is complete.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over the payload.
module instr_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  instr_loader_if.slave bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output loader_state_t dbg_state
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam loader_state_t TAIL_STATE = CSUM;
`else
  localparam loader_state_t TAIL_STATE = DONE;
`endif

  // Largest image is exactly 2^ADDR_WIDTH words, so lengths need one extra bit.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   idx_next;
  logic                  xfer;
  logic                  asm_clr;
  logic                  asm_take;
  logic [31:0]           asm_word;
  logic                  asm_last;
  logic                  hdr_oversize;
  logic                  csum_ok;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign asm_clr   = (state_q == IDLE) || (state_q == WRITE);
  assign asm_take  = xfer && ((state_q == LEN) || (state_q == DATA));
  assign idx_next  = word_idx_q + 1'b1;
  assign dbg_state = state_q;

  // Any header bit above the length field, or a length past the memory depth.
  assign hdr_oversize = ((asm_word >> (ADDR_WIDTH + 1)) != 32'd0) ||
                        (asm_word[ADDR_WIDTH:0] > MAX_LEN);

  byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (asm_clr),
    .take    (asm_take),
    .byte_in (bus.byte_data),
    .word    (asm_word),
    .last    (asm_last)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running XOR of payload bytes, restarted with every session.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (state_q == IDLE && start) begin
      csum_q <= 8'd0;
    end else if (state_q == DATA && xfer) begin
      csum_q <= csum_q ^ bus.byte_data;
    end
  end

  assign csum_ok = (bus.byte_data == csum_q);
`else
  assign csum_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (asm_last) begin
          if (hdr_oversize)            state_d = IDLE;
          else if (asm_word == 32'd0)  state_d = TAIL_STATE;
          else                         state_d = DATA;
        end
      end
      DATA: begin
        if (asm_last) state_d = WRITE;
      end
      WRITE: begin
        if (idx_next == len_q) state_d = TAIL_STATE;
        else                   state_d = DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM: begin
        if (xfer) state_d = csum_ok ? DONE : IDLE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    done           = 1'b0;
    case (state_q)
      LEN:   bus.byte_ready = 1'b1;
      DATA:  bus.byte_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CSUM:  bus.byte_ready = 1'b1;
`endif
      WRITE: bus.mem_we     = 1'b1;
      DONE:  done           = 1'b1;
      default: ;
    endcase
  end

  // Session registers: word counter, length, write port, hold and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx_q    <= '0;
      len_q         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        error      <= 1'b0;
        cpu_hold   <= 1'b1;
        word_idx_q <= '0;
      end
      if (state_q == LEN && asm_last) begin
        len_q <= asm_word[ADDR_WIDTH:0];
        if (hdr_oversize) error <= 1'b1;
      end
      if (state_q == DATA && asm_last) begin
        bus.mem_addr  <= DATA_WIDTH'({word_idx_q, 2'b00});
        bus.mem_wdata <= DATA_WIDTH'(asm_word);
      end
      if (state_q == WRITE) begin
        word_idx_q <= idx_next;
      end
      if (state_q == CSUM && xfer && !csum_ok) begin
        error <= 1'b1;
      end
      // Only a completed image releases the core; errors leave it held.
      if (state_q == DONE) begin
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frame-level reference model with an
// expected-write queue, randomized payloads and byte_valid gaps.
module tb_instr_loader;
  import loader_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int MAX_L = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cpu_hold;
  logic          done;
  logic          error;
  loader_state_t dbg_state;

  instr_loader_if #(.DATA_WIDTH(DW)) bus ();

  instr_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
  );

  // Clock and bookkeeping.
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          gap_max  = 0;
  logic [63:0] exp_q[$];   // {byte address, word} in expected write order
  logic [31:0] pay[$];     // payload words of the frame being sent

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every memory write must match the oldest expected write.
  logic [63:0] mon_e;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 64'(bus.mem_addr), 64'(mon_e[63:32]));
        check("we_data", 64'(bus.mem_wdata), 64'(mon_e[31:0]));
      end
    end
  end

  // Driver: optional idle gap, then hold the byte until it is accepted.
  // Called and returns on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int  g;
    int  t;
    bit  sent;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    sent = 1'b0;
    t    = 0;
    while (!sent && t < 200) begin
      if (bus.byte_ready === 1'b1) sent = 1'b1;
      @(negedge clk);
      t++;
    end
    if (!sent) check("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_hold", 64'(cpu_hold), 64'd1);
    check("start_ready", 64'(bus.byte_ready), 64'd1);
    check("start_err_clr", 64'(error), 64'd0);
  endtask

  task automatic send_header(input logic [31:0] hdr);
    for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8]);
  endtask

  // Whole session against the frame-level model: oversize lengths error out
  // after the header; otherwise word i lands at byte address 4*i.
  task automatic send_frame(input logic [31:0] hdr, input logic [7:0] csum_delta);
    logic [7:0]  cs;
    logic [31:0] w;
    int          len;
    cs = 8'd0;
    do_start();
    send_header(hdr);
    if (hdr > 32'(MAX_L)) begin
      bus.byte_valid = 1'b0;
      check("over_error", 64'(error), 64'd1);
      check("over_hold", 64'(cpu_hold), 64'd1);
      check("over_idle", 64'(dbg_state), 64'(IDLE));
      return;
    end
    len = int'(hdr);
    for (int i = 0; i < len; i++) begin
      w = pay[i];
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({32'(i * 4), w});
        send_byte(w[8*b +: 8]);
        cs = cs ^ w[8*b +: 8];
      end
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(cs ^ csum_delta);
    bus.byte_valid = 1'b0;
    if (csum_delta != 8'd0) begin
      check("csum_error", 64'(error), 64'd1);
      check("csum_no_done", 64'(done), 64'd0);
      check("csum_hold", 64'(cpu_hold), 64'd1);
      return;
    end
`else
    bus.byte_valid = 1'b0;
    if (len > 0) begin
      check("last_write_cycle", 64'(bus.mem_we), 64'd1);
      @(negedge clk);
    end
`endif
    check("done_pulse", 64'(done), 64'd1);
    check("done_hold", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    check("done_single", 64'(done), 64'd0);
    check("release_hold", 64'(cpu_hold), 64'd0);
    check("no_error", 64'(error), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic fill_pay(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back($urandom());
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_we"}, 64'(bus.mem_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  initial begin
    logic [31:0] w;
    rst            = 1'b1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed two-word image.
    pay.delete();
    pay.push_back(32'h0000_0013);
    pay.push_back(32'h0010_0093);
    send_frame(32'd2, 8'd0);

    // Empty image.
    pay.delete();
    send_frame(32'd0, 8'd0);

    // Oversize by one word, then a clean session clears the error.
    send_frame(32'(MAX_L + 1), 8'd0);
    fill_pay(1);
    send_frame(32'd1, 8'd0);

    // Oversize via a header bit above the length field.
    send_frame(32'h0001_0001, 8'd0);

    // Random images with random source gaps.
    for (int k = 0; k < 6; k++) begin
      gap_max = int'($urandom_range(3, 0));
      fill_pay(int'($urandom_range(8, 1)));
      send_frame(32'(pay.size()), 8'd0);
    end

    // Largest legal image.
    gap_max = 0;
    fill_pay(MAX_L);
    send_frame(32'(MAX_L), 8'd0);

    // Reset in the middle of the third word abandons the session.
    gap_max = 1;
    fill_pay(5);
    do_start();
    send_header(32'd5);
    for (int i = 0; i < 2; i++) begin
      w = pay[i];
      for (int b = 0; b < 4; b++) begin
        if (b == 3) exp_q.push_back({32'(i * 4), w});
        send_byte(w[8*b +: 8]);
      end
    end
    send_byte(pay[2][7:0]);
    send_byte(pay[2][15:8]);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    check("midrst_writes", 64'(exp_q.size()), 64'd0);
    fill_pay(1);
    send_frame(32'd1, 8'd0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum byte 0x13 completes; 0x12 faults and keeps the core held.
    gap_max = 0;
    pay.delete();
    pay.push_back(32'h0000_0013);
    send_frame(32'd1, 8'd0);
    send_frame(32'd1, 8'h01);
    check("csum_final_hold", 64'(cpu_hold), 64'd1);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
